// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared,
// wait-stated memory port. Outputs are combinational from the state register and
// op/fun. The only input-gated terms are mem_ready in FETCH and zero in BRANCH.
// A bounded wait counter sends the controller to TRAP if memory never answers.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] fun,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       grf_write,
    output logic [1:0] grf_dst,
    output logic [1:0] grf_wd_src,
    output logic       alu_srcb,
    output logic [2:0] alu_ctrl,
    output logic       sign_src,
    output logic [3:0] state_o,
    output logic       trap
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU = 4'd0,
        I_SUBU = 4'd1,
        I_JR   = 4'd2,
        I_ORI  = 4'd3,
        I_LUI  = 4'd4,
        I_LW   = 4'd5,
        I_SW   = 4'd6,
        I_BEQ  = 4'd7,
        I_J    = 4'd8,
        I_JAL  = 4'd9,
        I_ILL  = 4'd15
    } instr_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Last wait cycle allowed: the MEM_TIMEOUT-th consecutive wait traps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT) - CNT_ONE;

    // Classify the instruction register contents; anything unknown is illegal.
    function automatic instr_t decode(input logic [5:0] op_v, input logic [5:0] fun_v);
        instr_t res;
        case (op_v)
            6'h00: begin
                case (fun_v)
                    6'h21:   res = I_ADDU;
                    6'h23:   res = I_SUBU;
                    6'h08:   res = I_JR;
                    default: res = I_ILL;
                endcase
            end
            6'h0d:   res = I_ORI;
            6'h0f:   res = I_LUI;
            6'h23:   res = I_LW;
            6'h2b:   res = I_SW;
            6'h04:   res = I_BEQ;
            6'h02:   res = I_J;
            6'h03:   res = I_JAL;
            default: res = I_ILL;
        endcase
        return res;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_next_s;
    instr_t           instr_s;
    logic             wait_last_s;

    assign instr_s     = decode(op, fun);
    assign wait_last_s = (wait_cnt_r >= CNT_LAST);

    // State and wait-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= CNT_ZERO;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Next-state and wait-counter logic; the counter only runs while stalled in a memory state.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = CNT_ZERO;
        case (state_r)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    if (state_r == S_FETCH) begin
                        state_next_s = S_DECODE;
                    end else if (state_r == S_MEM_RD) begin
                        state_next_s = S_WB_MEM;
                    end else begin
                        state_next_s = S_FETCH;
                    end
                end else if (wait_last_s) begin
                    state_next_s = S_TRAP;
                end else begin
                    state_next_s    = state_r;
                    wait_cnt_next_s = wait_cnt_r + CNT_ONE;
                end
            end
            S_DECODE: begin
                case (instr_s)
                    I_ADDU, I_SUBU:    state_next_s = S_EXEC_R;
                    I_ORI, I_LUI:      state_next_s = S_EXEC_I;
                    I_LW, I_SW:        state_next_s = S_ADDR;
                    I_BEQ:             state_next_s = S_BRANCH;
                    I_J, I_JAL, I_JR:  state_next_s = S_JUMP;
                    default:           state_next_s = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_next_s = S_WB_ALU;
            S_ADDR: begin
                if (instr_s == I_LW) begin
                    state_next_s = S_MEM_RD;
                end else if (instr_s == I_SW) begin
                    state_next_s = S_MEM_WR;
                end else begin
                    state_next_s = S_TRAP;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_next_s = S_FETCH;
            S_TRAP:  state_next_s = S_TRAP;
            default: state_next_s = S_TRAP;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_src = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        grf_write    = 1'b0;
        grf_dst      = 2'b00;
        grf_wd_src   = 2'b00;
        alu_srcb     = 1'b0;
        alu_ctrl     = ALU_ADD;
        sign_src     = 1'b0;
        state_o      = 4'd0;
        trap         = 1'b0;
        if (!reset) begin
            state_o = 4'd0;
        end else begin
            state_o = state_r;
            case (state_r)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end else begin
                        ir_write = 1'b0;
                    end
                end
                S_DECODE: begin
                    trap = 1'b0;
                end
                S_EXEC_R, S_EXEC_I, S_WB_ALU: begin
                    // ALU select lines stay valid through write-back.
                    if (instr_s == I_SUBU) begin
                        alu_ctrl = ALU_SUB;
                    end else if (instr_s == I_ORI || instr_s == I_LUI) begin
                        alu_srcb = 1'b1;
                        alu_ctrl = ALU_OR;
                    end else begin
                        alu_ctrl = ALU_ADD;
                    end
                    if (state_r == S_WB_ALU) begin
                        grf_write  = 1'b1;
                        grf_dst    = (op == 6'h00) ? 2'b01 : 2'b00;
                        grf_wd_src = (instr_s == I_LUI) ? 2'b10 : 2'b00;
                    end else begin
                        grf_write = 1'b0;
                    end
                end
                S_ADDR, S_MEM_RD, S_MEM_WR: begin
                    alu_srcb = 1'b1;
                    alu_ctrl = ALU_ADD;
                    sign_src = 1'b1;
                    if (state_r != S_ADDR) begin
                        mem_req      = 1'b1;
                        mem_addr_src = 1'b1;
                        mem_we       = (state_r == S_MEM_WR);
                    end else begin
                        mem_req = 1'b0;
                    end
                end
                S_WB_MEM: begin
                    grf_write  = 1'b1;
                    grf_wd_src = 2'b01;
                end
                S_BRANCH: begin
                    alu_ctrl = ALU_SUB;
                    sign_src = 1'b1;
                    pc_write = zero;
                    pc_src   = 2'b01;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    if (instr_s == I_JR) begin
                        pc_src = 2'b11;
                    end else begin
                        pc_src = 2'b10;
                    end
                    if (instr_s == I_JAL) begin
                        // PC already holds PC+4, so it is the link value.
                        grf_write  = 1'b1;
                        grf_dst    = 2'b10;
                        grf_wd_src = 2'b11;
                    end else begin
                        grf_write = 1'b0;
                    end
                end
                S_TRAP:  trap = 1'b1;
                default: trap = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle pushes its hand-computed
// expected output bundle; a negedge monitor pops and compares against the DUT.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       we;
        logic       asrc;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       gw;
        logic [1:0] gd;
        logic [1:0] gws;
        logic       sb;
        logic [2:0] ac;
        logic       sg;
        logic       tr;
    } exp_t;

    //                        st     rqweasirpc  pcs   gw    gd     gws    sb    ac      sg    tr
    localparam exp_t R0      = {4'd0,  5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam exp_t F_W     = {4'd0,  5'b10000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam exp_t F_A     = {4'd0,  5'b10011, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam exp_t DEC     = {4'd1,  5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam exp_t EXR_ADD = {4'd2,  5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam exp_t EXR_SUB = {4'd2,  5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0};
    localparam exp_t EXI     = {4'd3,  5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 3'b010, 1'b0, 1'b0};
    localparam exp_t WB_ADDU = {4'd7,  5'b00000, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam exp_t WB_SUBU = {4'd7,  5'b00000, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0};
    localparam exp_t WB_ORI  = {4'd7,  5'b00000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 3'b010, 1'b0, 1'b0};
    localparam exp_t WB_LUI  = {4'd7,  5'b00000, 2'b00, 1'b1, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0, 1'b0};
    localparam exp_t ADDR    = {4'd4,  5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0};
    localparam exp_t MRD     = {4'd5,  5'b10100, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0};
    localparam exp_t MWR     = {4'd6,  5'b11100, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0};
    localparam exp_t WBM     = {4'd8,  5'b00000, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam exp_t BR_T    = {4'd9,  5'b00001, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 3'b001, 1'b1, 1'b0};
    localparam exp_t BR_N    = {4'd9,  5'b00000, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 3'b001, 1'b1, 1'b0};
    localparam exp_t J_J     = {4'd10, 5'b00001, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam exp_t J_JAL   = {4'd10, 5'b00001, 2'b10, 1'b1, 2'b10, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam exp_t J_JR    = {4'd10, 5'b00001, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam exp_t TRP     = {4'd15, 5'b00000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1};

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] fun;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       grf_write;
    logic [1:0] grf_dst;
    logic [1:0] grf_wd_src;
    logic       alu_srcb;
    logic [2:0] alu_ctrl;
    logic       sign_src;
    logic [3:0] state_o;
    logic       trap;

    exp_t  exp_q[$];
    string nm_q[$];
    int    checks;
    int    errors;
    logic  done;
    exp_t  act;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .fun          (fun),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_src (mem_addr_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .grf_write    (grf_write),
        .grf_dst      (grf_dst),
        .grf_wd_src   (grf_wd_src),
        .alu_srcb     (alu_srcb),
        .alu_ctrl     (alu_ctrl),
        .sign_src     (sign_src),
        .state_o      (state_o),
        .trap         (trap)
    );

    assign act = {state_o, mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src,
                  grf_write, grf_dst, grf_wd_src, alu_srcb, alu_ctrl, sign_src, trap};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and queue the output bundle expected during it.
    task automatic cyc(input string nm, input logic rst, input logic rdy, input logic z,
                       input logic [5:0] o, input logic [5:0] f, input exp_t e);
        reset     = rst;
        mem_ready = rdy;
        zero      = z;
        op        = o;
        fun       = f;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Fetch (accepted at once) followed by decode.
    task automatic fd(input string nm, input logic [5:0] o, input logic [5:0] f);
        cyc({nm, "_fetch"}, 1'b1, 1'b1, 1'b0, o, f, F_A);
        cyc({nm, "_decode"}, 1'b1, 1'b1, 1'b0, o, f, DEC);
    endtask

    // Monitor: compare each presented cycle against the head of the scoreboard.
    always @(negedge clk) begin
        if (done) begin
            checks = checks + 1;
            if (exp_q.size() != 0) begin
                errors = errors + 1;
                $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (exp_q.size() != 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            checks = checks + 1;
            if (act !== e) begin
                errors = errors + 1;
                $display("FAIL %s: got %h required %h (state_o got %0d required %0d)",
                         n, act, e, act.st, e.st);
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        done      = 1'b0;
        reset     = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        op        = 6'h00;
        fun       = 6'h00;
        @(posedge clk);
        #1;
        // Reset: everything low even with mem_ready high.
        cyc("rst_a", 1'b0, 1'b1, 1'b0, 6'h00, 6'h21, R0);
        cyc("rst_b", 1'b0, 1'b1, 1'b0, 6'h00, 6'h21, R0);
        // addu / subu / ori / lui
        fd("addu", 6'h00, 6'h21);
        cyc("addu_exec", 1'b1, 1'b1, 1'b0, 6'h00, 6'h21, EXR_ADD);
        cyc("addu_wb",   1'b1, 1'b1, 1'b0, 6'h00, 6'h21, WB_ADDU);
        fd("subu", 6'h00, 6'h23);
        cyc("subu_exec", 1'b1, 1'b1, 1'b0, 6'h00, 6'h23, EXR_SUB);
        cyc("subu_wb",   1'b1, 1'b1, 1'b0, 6'h00, 6'h23, WB_SUBU);
        fd("ori", 6'h0d, 6'h00);
        cyc("ori_exec", 1'b1, 1'b1, 1'b0, 6'h0d, 6'h00, EXI);
        cyc("ori_wb",   1'b1, 1'b1, 1'b0, 6'h0d, 6'h00, WB_ORI);
        fd("lui", 6'h0f, 6'h00);
        cyc("lui_exec", 1'b1, 1'b1, 1'b0, 6'h0f, 6'h00, EXI);
        cyc("lui_wb",   1'b1, 1'b1, 1'b0, 6'h0f, 6'h00, WB_LUI);
        // lw with three wait cycles; the 4th cycle's ready beats the timeout.
        fd("lw", 6'h23, 6'h00);
        cyc("lw_addr", 1'b1, 1'b1, 1'b0, 6'h23, 6'h00, ADDR);
        for (int i = 0; i < 3; i++) begin
            cyc("lw_wait", 1'b1, 1'b0, 1'b0, 6'h23, 6'h00, MRD);
        end
        cyc("lw_ack", 1'b1, 1'b1, 1'b0, 6'h23, 6'h00, MRD);
        cyc("lw_wb",  1'b1, 1'b1, 1'b0, 6'h23, 6'h00, WBM);
        // sw
        fd("sw", 6'h2b, 6'h00);
        cyc("sw_addr", 1'b1, 1'b1, 1'b0, 6'h2b, 6'h00, ADDR);
        cyc("sw_mem",  1'b1, 1'b1, 1'b0, 6'h2b, 6'h00, MWR);
        // beq taken / not taken
        fd("beq_t", 6'h04, 6'h00);
        cyc("beq_taken", 1'b1, 1'b1, 1'b1, 6'h04, 6'h00, BR_T);
        fd("beq_n", 6'h04, 6'h00);
        cyc("beq_not",   1'b1, 1'b1, 1'b0, 6'h04, 6'h00, BR_N);
        // jal
        fd("jal", 6'h03, 6'h00);
        cyc("jal_jump", 1'b1, 1'b1, 1'b0, 6'h03, 6'h00, J_JAL);
        // j after three fetch waits (ready on the last allowed cycle)
        for (int i = 0; i < 3; i++) begin
            cyc("j_fwait", 1'b1, 1'b0, 1'b0, 6'h02, 6'h00, F_W);
        end
        cyc("j_fetch",  1'b1, 1'b1, 1'b0, 6'h02, 6'h00, F_A);
        cyc("j_decode", 1'b1, 1'b1, 1'b0, 6'h02, 6'h00, DEC);
        cyc("j_jump",   1'b1, 1'b1, 1'b0, 6'h02, 6'h00, J_J);
        // jr
        fd("jr", 6'h00, 6'h08);
        cyc("jr_jump", 1'b1, 1'b1, 1'b0, 6'h00, 6'h08, J_JR);
        // illegal opcode -> TRAP, held until reset
        fd("ill_op", 6'h3f, 6'h00);
        cyc("ill_trap", 1'b1, 1'b1, 1'b0, 6'h3f, 6'h00, TRP);
        cyc("ill_hold", 1'b1, 1'b1, 1'b0, 6'h3f, 6'h00, TRP);
        cyc("ill_rst",  1'b0, 1'b1, 1'b0, 6'h3f, 6'h00, R0);
        // illegal R-type funct -> TRAP
        fd("ill_fun", 6'h00, 6'h20);
        cyc("illf_trap", 1'b1, 1'b1, 1'b0, 6'h00, 6'h20, TRP);
        cyc("illf_rst",  1'b0, 1'b0, 1'b0, 6'h00, 6'h20, R0);
        // fetch timeout after four wait cycles
        for (int i = 0; i < 4; i++) begin
            cyc("to_fwait", 1'b1, 1'b0, 1'b0, 6'h00, 6'h21, F_W);
        end
        cyc("to_trap", 1'b1, 1'b0, 1'b0, 6'h00, 6'h21, TRP);
        cyc("to_hold", 1'b1, 1'b1, 1'b0, 6'h00, 6'h21, TRP);
        cyc("to_rst",  1'b0, 1'b0, 1'b0, 6'h00, 6'h21, R0);
        // reset in the middle of a MEM_WR wait, then restart
        fd("swr", 6'h2b, 6'h00);
        cyc("swr_addr",  1'b1, 1'b1, 1'b0, 6'h2b, 6'h00, ADDR);
        cyc("swr_wait",  1'b1, 1'b0, 1'b0, 6'h2b, 6'h00, MWR);
        cyc("swr_wait",  1'b1, 1'b0, 1'b0, 6'h2b, 6'h00, MWR);
        cyc("swr_rst_a", 1'b0, 1'b0, 1'b0, 6'h2b, 6'h00, R0);
        cyc("swr_rst_b", 1'b0, 1'b1, 1'b0, 6'h2b, 6'h00, R0);
        cyc("swr_fwait", 1'b1, 1'b0, 1'b0, 6'h2b, 6'h00, F_W);
        fd("swr2", 6'h2b, 6'h00);
        cyc("swr2_addr", 1'b1, 1'b1, 1'b0, 6'h2b, 6'h00, ADDR);
        cyc("swr2_mem",  1'b1, 1'b1, 1'b0, 6'h2b, 6'h00, MWR);
        cyc("swr2_next", 1'b1, 1'b0, 1'b0, 6'h00, 6'h21, F_W);
        done = 1'b1;
    end

endmodule
